// File: rtl/arb_pkg.sv
// Shared definitions for the data-RAM port arbiter.
//   SLOT_CPU / SLOT_HOST : requester slot indices (vector load/store, host loader/DMA)
//   ARB_*_W              : default widths used by the arbiter and its return pipe
//   rd_tag_t             : one entry of the read-return pipe {valid, issuing slot}
package arb_pkg;

  localparam int SLOT_CPU   = 0;
  localparam int SLOT_HOST  = 1;

  localparam int ARB_ADDR_W = 14;
  localparam int ARB_DATA_W = 256;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/arb_return_pipe.sv
// Read-return tracker: carries a {valid, id} tag alongside each RAM read for
// READ_LAT cycles and steers the RAM's read data to the slot that issued it.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (flushes in-flight tags)
//   issueValid, issueId : a read was granted this cycle, and to which slot
//   ramRdata            : RAM read data, aligned with the last pipe stage
//   rvalid              : one-hot per-slot read-data-valid
//   rdata               : read data, zero whenever no rvalid bit is set
module arb_return_pipe
  import arb_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int DATA_W   = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueValid,
  input  logic              issueId,
  input  logic [DATA_W-1:0] ramRdata,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata
);

  rd_tag_t [READ_LAT-1:0] tagPipe;
  rd_tag_t                outTag;

  always_ff @(posedge clk) begin
    if (reset) begin
      tagPipe <= '0;
    end else begin
      tagPipe[0] <= {issueValid, issueId};
      for (int k = 1; k < READ_LAT; k++) tagPipe[k] <= tagPipe[k-1];
    end
  end

  assign outTag = tagPipe[READ_LAT-1];

  // Gating with reset keeps a dropped read from surfacing even when the
  // return stage is also the capture stage (READ_LAT == 1).
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (outTag.valid && !reset) begin
      rvalid[outTag.id] = 1'b1;
      rdata             = ramRdata;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-slot arbiter for the single data-RAM port. Slot 0 is the vector
// load/store path, slot 1 the host loader/DMA. One access is granted per cycle,
// round-robin on ties, with an optional locked burst of up to MAX_BURST grants.
// The granted slot drives the RAM combinationally; reads are tracked through
// the RAM latency and returned to the issuing slot.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req/req_we/req_lock        : per-slot request, write flag, burst-lock request
//   req_addr/req_be/req_wdata  : per-slot fields, slot i at [i*W +: W]
//   gnt                        : one-hot access accepted this cycle
//   rvalid, rdata              : one-hot read return, data broadcast to both slots
//   *_RAM                      : RAM macro port
//   gnt_cnt0/gnt_cnt1/wait_cnt : saturating statistics, present only with ARB_STATS_EN
// Build option: define ARB_STATS_EN to add the statistics counters and ports.
module ram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int BE_W      = DATA_W / 8,
  parameter int READ_LAT  = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [1:0]          req_lock,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*BE_W-1:0]   req_be,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   address_RAM,
  output logic [BE_W-1:0]     byteena_RAM,
  output logic [DATA_W-1:0]   writeData_RAM,
  output logic                rden_RAM,
  output logic                wren_RAM,
  input  logic [DATA_W-1:0]   readData_RAM
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]         gnt_cnt0,
  output logic [31:0]         gnt_cnt1,
  output logic [31:0]         wait_cnt
`endif
);

  localparam int              CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [1:0][ADDR_W-1:0] slotAddr;
  logic [1:0][BE_W-1:0]   slotBe;
  logic [1:0][DATA_W-1:0] slotWdata;

  assign slotAddr  = req_addr;
  assign slotBe    = req_be;
  assign slotWdata = req_wdata;

  logic             lastGnt;
  logic             owner;
  logic             ownerValid;
  logic [CNT_W-1:0] burstCnt;

  logic [1:0]       liveReq;
  logic             grantValid;
  logic             gSel;

  // Arbitration. ownerValid already carries the owner's lock as sampled on its
  // previous grant, and is cleared by any idle cycle, so a lock only survives
  // back-to-back requests.
  always_comb begin
    liveReq    = reset ? 2'b00 : req;
    grantValid = |liveReq;
    gSel       = 1'(SLOT_CPU);
    case (liveReq)
      2'b01: gSel = 1'(SLOT_CPU);
      2'b10: gSel = 1'(SLOT_HOST);
      2'b11: begin
        if (ownerValid && (burstCnt < BURST_MAX)) gSel = owner;
        else                                      gSel = ~lastGnt;
      end
      default: gSel = 1'(SLOT_CPU);
    endcase
  end

  // Granted slot drives the RAM with no added latency; idle drives all zeros.
  always_comb begin
    gnt           = '0;
    address_RAM   = '0;
    byteena_RAM   = '0;
    writeData_RAM = '0;
    rden_RAM      = 1'b0;
    wren_RAM      = 1'b0;
    if (grantValid) begin
      gnt[gSel]     = 1'b1;
      address_RAM   = slotAddr[gSel];
      writeData_RAM = slotWdata[gSel];
      wren_RAM      = req_we[gSel];
      rden_RAM      = ~req_we[gSel];
      byteena_RAM   = req_we[gSel] ? slotBe[gSel] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lastGnt    <= 1'b1;
      owner      <= 1'b0;
      ownerValid <= 1'b0;
      burstCnt   <= '0;
    end else if (grantValid) begin
      lastGnt <= gSel;
      if (gSel == owner && ownerValid) begin
        if (burstCnt != BURST_MAX) burstCnt <= burstCnt + 1'b1;
      end else begin
        owner    <= gSel;
        burstCnt <= CNT_W'(1);
      end
      ownerValid <= req_lock[gSel];
    end else begin
      ownerValid <= 1'b0;
      burstCnt   <= '0;
    end
  end

  arb_return_pipe #(
    .READ_LAT (READ_LAT),
    .DATA_W   (DATA_W)
  ) uRetPipe (
    .clk        (clk),
    .reset      (reset),
    .issueValid (grantValid & ~req_we[gSel]),
    .issueId    (gSel),
    .ramRdata   (readData_RAM),
    .rvalid     (rvalid),
    .rdata      (rdata)
  );

`ifdef ARB_STATS_EN
  // wait_cnt counts cycles, not slots: one tick whenever any live request lost.
  logic waitCycle;
  assign waitCycle = |(liveReq & ~gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      wait_cnt <= '0;
    end else begin
      if (gnt[0] && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 32'd1;
      if (gnt[1] && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 32'd1;
      if (waitCycle && wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed steps push expected grants and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 256;
  localparam int BW = 32;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req = '0, req_we = '0, req_lock = '0;
  logic [AW-1:0] a0, a1;
  logic [BW-1:0] be0, be1;
  logic [DW-1:0] wd0, wd1;
  logic [2*AW-1:0] req_addr;
  logic [2*BW-1:0] req_be;
  logic [2*DW-1:0] req_wdata;
  logic [1:0] gnt, rvalid;
  logic [DW-1:0] rdata, writeData_RAM, readData_RAM;
  logic [AW-1:0] address_RAM;
  logic [BW-1:0] byteena_RAM;
  logic rden_RAM, wren_RAM;
`ifdef ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, wait_cnt;
`endif

  assign req_addr  = {a1, a0};
  assign req_be    = {be1, be0};
  assign req_wdata = {wd1, wd0};

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .address_RAM(address_RAM), .byteena_RAM(byteena_RAM), .writeData_RAM(writeData_RAM),
    .rden_RAM(rden_RAM), .wren_RAM(wren_RAM), .readData_RAM(readData_RAM)
`ifdef ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .wait_cnt(wait_cnt)
`endif
  );

  // RAM model: data is a fixed pattern of the address presented RL cycles ago.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{(32'hC0DE0000 | {18'd0, a})}};
  endfunction

  logic [AW-1:0] ramA [RL];
  always @(posedge clk) begin
    ramA[0] <= address_RAM;
    for (int k = 1; k < RL; k++) ramA[k] <= ramA[k-1];
  end
  assign readData_RAM = pat(ramA[RL-1]);

  typedef struct {
    logic [1:0]    g;
    logic          we;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } gexp_t;
  typedef struct {
    logic [1:0]    g;
    logic [DW-1:0] d;
  } rexp_t;

  gexp_t gntQ[$];
  rexp_t rvQ[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
  endtask

  // Drive one cycle of requests; eg is the hand-computed expected grant.
  task automatic step(input logic [1:0] r, input logic [1:0] we, input logic [1:0] lk,
                      input logic [1:0] eg, input bit expRv = 1'b1);
    gexp_t e;
    int s;
    req = r; req_we = we; req_lock = lk;
    if (eg != 2'b00) begin
      s    = int'(eg[1]);
      e.g  = eg;
      e.we = we[s];
      e.a  = s ? a1 : a0;
      e.be = we[s] ? (s ? be1 : be0) : '0;
      e.wd = s ? wd1 : wd0;
      gntQ.push_back(e);
      if (!we[s] && expRv) rvQ.push_back('{g: eg, d: pat(e.a)});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  // Requests are held high during reset to show they are ignored.
  task automatic doReset();
    reset = 1'b1; req = 2'b11; req_we = 2'b00; req_lock = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; req = 2'b00;
  endtask

  always @(negedge clk) begin : monitor
    gexp_t e;
    rexp_t r;
    if (reset) begin
      chk("rst_gnt", DW'(gnt), '0);
      chk("rst_ram_en", DW'({rden_RAM, wren_RAM}), '0);
      chk("rst_rvalid", DW'(rvalid), '0);
      chk("rst_rdata", rdata, '0);
    end else begin
      if (gnt != 2'b00) begin
        if (gntQ.size() == 0) chk("gnt_unexpected", DW'(gnt), '0);
        else begin
          e = gntQ.pop_front();
          chk("gnt", DW'(gnt), DW'(e.g));
          chk("ram_en", DW'({rden_RAM, wren_RAM}), DW'({~e.we, e.we}));
          chk("ram_addr", DW'(address_RAM), DW'(e.a));
          chk("ram_be", DW'(byteena_RAM), DW'(e.be));
          chk("ram_wdata", writeData_RAM, e.wd);
        end
      end else begin
        chk("idle_ram_ctl", DW'({rden_RAM, wren_RAM, address_RAM, byteena_RAM}), '0);
        chk("idle_ram_wdata", writeData_RAM, '0);
      end
      if (rvalid != 2'b00) begin
        if (rvQ.size() == 0) chk("rvalid_unexpected", DW'(rvalid), '0);
        else begin
          r = rvQ.pop_front();
          chk("rvalid", DW'(rvalid), DW'(r.g));
          chk("rdata", rdata, r.d);
        end
      end else begin
        chk("rdata_idle", rdata, '0);
      end
    end
  end

  initial begin
    a0 = 14'h0010; a1 = 14'h0020;
    be0 = 32'h0F0F0F0F; be1 = 32'hF0F0F0F0;
    wd0 = {32{8'h3C}}; wd1 = {32{8'hC3}};

    // Single read from reset: slot0 wins immediately, returns 2 cycles later.
    doReset();
    step(2'b01, 2'b00, 2'b00, 2'b01);
    idle(4);

    // Tie, no lock: strict alternation starting with slot0.
    doReset();
    repeat (3) begin
      step(2'b11, 2'b00, 2'b00, 2'b01);
      step(2'b11, 2'b00, 2'b00, 2'b10);
    end
`ifdef ARB_STATS_EN
    chk("stat_gnt_cnt0", DW'(gnt_cnt0), DW'(32'd3));
    chk("stat_gnt_cnt1", DW'(gnt_cnt1), DW'(32'd3));
    chk("stat_wait_cnt", DW'(wait_cnt), DW'(32'd6));
`endif
    idle(4);

    // Locked burst: slot1 locks after its first tie win, holds 4 grants.
    doReset();
    step(2'b11, 2'b00, 2'b10, 2'b01);
    repeat (4) step(2'b11, 2'b00, 2'b10, 2'b10);
    step(2'b11, 2'b00, 2'b10, 2'b01);
    step(2'b11, 2'b00, 2'b10, 2'b10);
    idle(4);

    // Host write at top address: full byte enables, no read return.
    doReset();
    a1 = 14'h3FFF; be1 = 32'hFFFFFFFF; wd1 = {32{8'hA5}};
    step(2'b10, 2'b10, 2'b00, 2'b10);
    idle(5);

    // Reset one cycle after a read grant drops the read; first tie after goes to slot0.
    step(2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
    reset = 1'b1; req = 2'b00;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    step(2'b11, 2'b00, 2'b00, 2'b01);
    step(2'b11, 2'b00, 2'b00, 2'b10);
    idle(4);

    chk("gnt_queue_drained", DW'(gntQ.size()), '0);
    chk("rv_queue_drained", DW'(rvQ.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
